// File: rtl/pll_dlf_lock_ctrl.sv
// PLL frequency-acquisition ramp, PI loop filter and lock detector on the reference clock.
// Drives the DCO control word from TDC phase-error samples after a timed linear ramp.
module pll_dlf_lock_ctrl #(
   parameter int PE_W             = 12,
   parameter int DCO_W            = 16,
   parameter int KP_SHIFT         = 2,
   parameter int KI_SHIFT         = 6,
   parameter int ACQ_CYCLES       = 64,
   parameter int INIT_CODE        = 16384,
   parameter int LOCK_TOL         = 8,
   parameter int LOCK_COUNT_MAX   = 10,
   parameter int UNLOCK_COUNT_MAX = 4
) (
   input  logic             rclk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             skip_phase_lock,
   input  logic [DCO_W-1:0] target_code,
   input  logic [PE_W-1:0]  pe,
   input  logic             pe_valid,
   output logic [DCO_W-1:0] dco_code,
   output logic [1:0]       state,
   output logic             freq_acq_done,
   output logic             lock,
   output logic             lost_lock
);

   // pe is consumed on every rclk edge with pe_valid=1; there is no ready, the filter never stalls.

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACQ    = 2'd1;
   localparam logic [1:0] S_TRACK  = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   localparam int ACQ_CW = (ACQ_CYCLES > 1) ? $clog2(ACQ_CYCLES) : 1;
   localparam int STEP_W = $clog2(ACQ_CYCLES + 1) + 1;
   localparam int MUL_W  = DCO_W + STEP_W + 2;
   localparam int INT_W  = DCO_W + 2;
   localparam int SUM_W  = ((INT_W > PE_W) ? INT_W : PE_W) + 2;
   localparam int GC_W   = $clog2(LOCK_COUNT_MAX + 1);
   localparam int BC_W   = $clog2(UNLOCK_COUNT_MAX + 1);

   localparam logic [DCO_W-1:0]        INIT_C   = DCO_W'(INIT_CODE);
   localparam logic signed [MUL_W-1:0] INIT_M   = MUL_W'(INIT_CODE);
   localparam logic signed [MUL_W-1:0] ONE_M    = MUL_W'(1);
   localparam logic signed [MUL_W-1:0] ACQ_DIV  = MUL_W'(ACQ_CYCLES);
   localparam logic signed [SUM_W-1:0] ZERO_S   = '0;
   localparam logic signed [SUM_W-1:0] CODE_MAX = {{(SUM_W-DCO_W){1'b0}}, {DCO_W{1'b1}}};
   localparam logic [ACQ_CW-1:0]       ACQ_LAST = ACQ_CW'(ACQ_CYCLES - 1);
   localparam logic [GC_W-1:0]         GC_LAST  = GC_W'(LOCK_COUNT_MAX - 1);
   localparam logic [GC_W-1:0]         GC_FULL  = GC_W'(LOCK_COUNT_MAX);
   localparam logic [BC_W-1:0]         BC_LAST  = BC_W'(UNLOCK_COUNT_MAX - 1);
   localparam logic [PE_W-1:0]         PE_MIN   = {1'b1, {(PE_W-1){1'b0}}};
   localparam logic [PE_W-1:0]         PE_MAX   = {1'b0, {(PE_W-1){1'b1}}};
   localparam logic [31:0]             TOL_U    = 32'(LOCK_TOL);

   logic [ACQ_CW-1:0]       acq_cnt;
   logic [GC_W-1:0]         good_cnt;
   logic [BC_W-1:0]         bad_cnt;
   logic signed [INT_W-1:0] integ;

   logic signed [MUL_W-1:0] ramp_diff;
   logic signed [MUL_W-1:0] ramp_step;
   logic signed [MUL_W-1:0] ramp_prod;
   logic signed [MUL_W-1:0] ramp_quot;
   logic [DCO_W-1:0]        ramp_code;

   logic signed [SUM_W-1:0] pe_s;
   logic signed [SUM_W-1:0] i_sum;
   logic signed [SUM_W-1:0] i_new;
   logic signed [SUM_W-1:0] p_sum;
   logic signed [SUM_W-1:0] p_new;
   logic signed [INT_W-1:0] integ_new;
   logic [DCO_W-1:0]        code_new;

   logic [PE_W-1:0]         pe_abs;
   logic                    pe_good;
   logic                    sample;
   logic                    good_smp;

   // Ramp point is recomputed from the live target so a mid-ramp change bends the trajectory.
   always_comb begin
      ramp_diff = $signed(MUL_W'(target_code)) - INIT_M;
      ramp_step = $signed(MUL_W'(acq_cnt)) + ONE_M;
      ramp_prod = ramp_diff * ramp_step;
      ramp_quot = ramp_prod / ACQ_DIV;
      ramp_code = INIT_C + DCO_W'(ramp_quot);
   end

   // Integrator saturates to the DCO range so a long error run cannot wind it up.
   always_comb begin
      pe_s  = SUM_W'($signed(pe));
      i_sum = SUM_W'(integ) + (pe_s >>> KI_SHIFT);
      if (i_sum < ZERO_S) begin
         i_new = ZERO_S;
      end else if (i_sum > CODE_MAX) begin
         i_new = CODE_MAX;
      end else begin
         i_new = i_sum;
      end
      p_sum = i_new + (pe_s >>> KP_SHIFT);
      if (p_sum < ZERO_S) begin
         p_new = ZERO_S;
      end else if (p_sum > CODE_MAX) begin
         p_new = CODE_MAX;
      end else begin
         p_new = p_sum;
      end
      integ_new = INT_W'(i_new);
      code_new  = DCO_W'(p_new);
   end

   always_comb begin
      if (pe == PE_MIN) begin
         pe_abs = PE_MAX;
      end else if (pe[PE_W-1]) begin
         pe_abs = -pe;
      end else begin
         pe_abs = pe;
      end
      pe_good  = (32'(pe_abs) <= TOL_U);
      sample   = skip_phase_lock | pe_valid;
      good_smp = skip_phase_lock | pe_good;
   end

   always_ff @(posedge rclk) begin
      if (!rst_n || !en) begin
         state         <= S_IDLE;
         dco_code      <= INIT_C;
         integ         <= '0;
         acq_cnt       <= '0;
         good_cnt      <= '0;
         bad_cnt       <= '0;
         freq_acq_done <= 1'b0;
         lock          <= 1'b0;
         lost_lock     <= 1'b0;
      end else begin
         lost_lock <= 1'b0;
         case (state)
            S_IDLE: begin
               state    <= S_ACQ;
               acq_cnt  <= '0;
               dco_code <= INIT_C;
            end
            S_ACQ: begin
               if (acq_cnt == ACQ_LAST) begin
                  dco_code      <= target_code;
                  integ         <= $signed({2'b00, target_code});
                  freq_acq_done <= 1'b1;
                  state         <= S_TRACK;
               end else begin
                  dco_code <= ramp_code;
                  acq_cnt  <= acq_cnt + 1'b1;
               end
            end
            S_TRACK, S_LOCKED: begin
               if (skip_phase_lock) begin
                  dco_code <= target_code;
                  integ    <= $signed({2'b00, target_code});
               end else if (pe_valid) begin
                  integ    <= integ_new;
                  dco_code <= code_new;
               end
               if (sample) begin
                  if (state == S_TRACK) begin
                     if (good_smp) begin
                        if (good_cnt == GC_LAST) begin
                           good_cnt <= GC_FULL;
                           bad_cnt  <= '0;
                           state    <= S_LOCKED;
                           lock     <= 1'b1;
                        end else begin
                           good_cnt <= good_cnt + 1'b1;
                        end
                     end else begin
                        good_cnt <= '0;
                     end
                  end else begin
                     if (!good_smp) begin
                        if (bad_cnt == BC_LAST) begin
                           bad_cnt   <= '0;
                           good_cnt  <= '0;
                           state     <= S_TRACK;
                           lock      <= 1'b0;
                           lost_lock <= 1'b1;
                        end else begin
                           bad_cnt <= bad_cnt + 1'b1;
                        end
                     end else begin
                        bad_cnt <= '0;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_dlf_lock_ctrl.sv
// Bench for pll_dlf_lock_ctrl: directed scenarios plus a randomized run against
// an integer-arithmetic reference model of the ramp, PI filter and lock rules.
module tb_pll_dlf_lock_ctrl;

   localparam int PE_W  = 12;
   localparam int DCO_W = 16;
   localparam int KP    = 2;
   localparam int KI    = 6;
   localparam int ACQ   = 64;
   localparam int INIT  = 16384;
   localparam int TOL   = 8;
   localparam int LCM   = 10;
   localparam int UCM   = 4;
   localparam int CMAX  = 65535;

   logic             rclk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             skip_phase_lock;
   logic [DCO_W-1:0] target_code;
   logic [PE_W-1:0]  pe;
   logic             pe_valid;
   logic [DCO_W-1:0] dco_code;
   logic [1:0]       state;
   logic             freq_acq_done;
   logic             lock;
   logic             lost_lock;

   int checks = 0;
   int errors = 0;

   int m_state, m_code, m_integ, m_acq, m_good, m_bad;
   bit m_lock, m_done, m_lost;

   logic [DCO_W-1:0] exp_q[$];

   pll_dlf_lock_ctrl #(
      .PE_W(PE_W), .DCO_W(DCO_W), .KP_SHIFT(KP), .KI_SHIFT(KI), .ACQ_CYCLES(ACQ),
      .INIT_CODE(INIT), .LOCK_TOL(TOL), .LOCK_COUNT_MAX(LCM), .UNLOCK_COUNT_MAX(UCM)
   ) dut (
      .rclk(rclk), .rst_n(rst_n), .en(en), .skip_phase_lock(skip_phase_lock),
      .target_code(target_code), .pe(pe), .pe_valid(pe_valid), .dco_code(dco_code),
      .state(state), .freq_acq_done(freq_acq_done), .lock(lock), .lost_lock(lost_lock)
   );

   always #5 rclk = ~rclk;

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int clamp_code(input int v);
      if (v < 0) return 0;
      if (v > CMAX) return CMAX;
      return v;
   endfunction

   task automatic model_step();
      int  pe_i, abs_pe;
      bit  smp, good;
      m_lost = 1'b0;
      if (!rst_n || !en) begin
         m_state = 0; m_code = INIT; m_integ = 0; m_acq = 0;
         m_good = 0; m_bad = 0; m_lock = 1'b0; m_done = 1'b0;
         return;
      end
      pe_i   = $signed(pe);
      abs_pe = (pe_i < 0) ? -pe_i : pe_i;
      if (abs_pe > 2047) abs_pe = 2047;
      case (m_state)
         0: begin
            m_state = 1; m_acq = 0; m_code = INIT;
         end
         1: begin
            if (m_acq == ACQ - 1) begin
               m_code = int'(target_code); m_integ = int'(target_code);
               m_done = 1'b1; m_state = 2;
            end else begin
               m_code = INIT + ((int'(target_code) - INIT) * (m_acq + 1)) / ACQ;
               m_acq++;
            end
         end
         default: begin
            smp  = skip_phase_lock || pe_valid;
            good = skip_phase_lock || (abs_pe <= TOL);
            if (skip_phase_lock) begin
               m_code = int'(target_code); m_integ = int'(target_code);
            end else if (pe_valid) begin
               m_integ = clamp_code(m_integ + floor_div(pe_i, 2 ** KI));
               m_code  = clamp_code(m_integ + floor_div(pe_i, 2 ** KP));
            end
            if (smp && m_state == 2) begin
               if (good) begin
                  m_good++;
                  if (m_good == LCM) begin
                     m_state = 3; m_lock = 1'b1; m_bad = 0;
                  end
               end else begin
                  m_good = 0;
               end
            end else if (smp) begin
               if (!good) begin
                  m_bad++;
                  if (m_bad == UCM) begin
                     m_state = 2; m_lock = 1'b0; m_lost = 1'b1; m_good = 0; m_bad = 0;
                  end
               end else begin
                  m_bad = 0;
               end
            end
         end
      endcase
   endtask

   task automatic cyc(input bit r, input bit e, input bit s, input int tgt, input int p, input bit v);
      rst_n           = r;
      en              = e;
      skip_phase_lock = s;
      target_code     = DCO_W'(tgt);
      pe              = PE_W'(p);
      pe_valid        = v;
      @(posedge rclk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 20000, 0, 1'b0);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (dco_code !== 16'd16384) begin errors++; $display("FAIL reset_code got=%0d exp=16384", dco_code); end
      checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock got=%0b exp=0", lock); end
      checks++; if (freq_acq_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", freq_acq_done); end
      checks++; if (lost_lock !== 1'b0) begin errors++; $display("FAIL reset_lost got=%0b exp=0", lost_lock); end
   endtask

   task automatic test_ramp();
      logic [DCO_W-1:0] exp;
      for (int k = 0; k < ACQ; k++) exp_q.push_back(DCO_W'(INIT + ((20000 - INIT) * (k + 1)) / ACQ));
      cyc(1'b1, 1'b1, 1'b0, 20000, 0, 1'b0);
      checks++; if (state !== 2'd1 || dco_code !== 16'd16384) begin
         errors++; $display("FAIL ramp_enter got state=%0d code=%0d exp state=1 code=16384", state, dco_code);
      end
      for (int k = 0; k < ACQ; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 20000, int'($urandom_range(0, 4095)) - 2048, 1'b1);
         exp = exp_q.pop_front();
         checks++; if (dco_code !== exp) begin
            errors++; $display("FAIL ramp_code k=%0d got=%0d exp=%0d", k, dco_code, exp);
         end
         if (k == 0) begin
            checks++; if (dco_code !== 16'd16440) begin errors++; $display("FAIL ramp_first got=%0d exp=16440", dco_code); end
         end
      end
      checks++; if (dco_code !== 16'd20000 || freq_acq_done !== 1'b1 || state !== 2'd2) begin
         errors++; $display("FAIL ramp_done got code=%0d done=%0b state=%0d exp 20000/1/2", dco_code, freq_acq_done, state);
      end
   endtask

   task automatic test_integral();
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 20000, 64, 1'b1);
         checks++; if (dco_code !== DCO_W'(20017 + k) || dco_code !== DCO_W'(m_code)) begin
            errors++; $display("FAIL integ_step k=%0d got=%0d exp=%0d", k, dco_code, 20017 + k);
         end
      end
   endtask

   task automatic test_lock();
      int pat[5] = '{100, 100, 0, 100, 100};
      for (int k = 0; k < LCM; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 20000, 0, 1'b1);
         checks++; if (lock !== (k == LCM - 1) || state !== ((k == LCM - 1) ? 2'd3 : 2'd2)) begin
            errors++; $display("FAIL lock_acquire k=%0d got lock=%0b state=%0d", k, lock, state);
         end
      end
      for (int k = 0; k < UCM; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 20000, 100, 1'b1);
         checks++; if (lock !== (k < UCM - 1) || lost_lock !== (k == UCM - 1) || state !== ((k < UCM - 1) ? 2'd3 : 2'd2)) begin
            errors++; $display("FAIL lock_loss k=%0d got lock=%0b lost=%0b state=%0d", k, lock, lost_lock, state);
         end
      end
      cyc(1'b1, 1'b1, 1'b0, 20000, 0, 1'b0);
      checks++; if (lost_lock !== 1'b0 || lock !== 1'b0 || state !== 2'd2) begin
         errors++; $display("FAIL lost_pulse_width got lost=%0b lock=%0b state=%0d exp 0/0/2", lost_lock, lock, state);
      end
      repeat (LCM) cyc(1'b1, 1'b1, 1'b0, 20000, 0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 20000, pat[k], 1'b1);
         checks++; if (lock !== 1'b1 || lost_lock !== 1'b0 || state !== 2'd3) begin
            errors++; $display("FAIL lock_hysteresis k=%0d got lock=%0b lost=%0b state=%0d", k, lock, lost_lock, state);
         end
      end
   endtask

   task automatic test_abort();
      checks++; if (lock !== 1'b1) begin errors++; $display("FAIL pre_abort_lock got=%0b exp=1", lock); end
      cyc(1'b1, 1'b0, 1'b0, 20000, 100, 1'b1);
      checks++; if (state !== 2'd0 || dco_code !== 16'd16384 || lock !== 1'b0 || lost_lock !== 1'b0 || freq_acq_done !== 1'b0) begin
         errors++; $display("FAIL abort_locked got state=%0d code=%0d lock=%0b lost=%0b done=%0b", state, dco_code, lock, lost_lock, freq_acq_done);
      end
      repeat (20) cyc(1'b1, 1'b1, 1'b0, 30000, 0, 1'b1);
      checks++; if (state !== 2'd1 || dco_code !== DCO_W'(m_code)) begin
         errors++; $display("FAIL abort_midacq_pre got state=%0d code=%0d exp state=1 code=%0d", state, dco_code, m_code);
      end
      cyc(1'b1, 1'b0, 1'b0, 30000, 0, 1'b1);
      checks++; if (state !== 2'd0 || dco_code !== 16'd16384 || lost_lock !== 1'b0) begin
         errors++; $display("FAIL abort_midacq got state=%0d code=%0d lost=%0b", state, dco_code, lost_lock);
      end
      repeat (70) cyc(1'b1, 1'b1, 1'b0, 30000, 0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 30000, 0, 1'b1);
      checks++; if (state !== 2'd0 || dco_code !== 16'd16384 || freq_acq_done !== 1'b0 || lock !== 1'b0) begin
         errors++; $display("FAIL reset_with_en got state=%0d code=%0d done=%0b lock=%0b", state, dco_code, freq_acq_done, lock);
      end
   endtask

   task automatic test_saturation();
      repeat (1 + ACQ) cyc(1'b1, 1'b1, 1'b0, 65535, 0, 1'b0);
      checks++; if (state !== 2'd2 || dco_code !== 16'd65535) begin
         errors++; $display("FAIL sat_ramp got state=%0d code=%0d exp 2/65535", state, dco_code);
      end
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 65535, 2047, 1'b1);
         checks++; if (dco_code !== 16'd65535) begin errors++; $display("FAIL sat_hold k=%0d got=%0d exp=65535", k, dco_code); end
      end
      cyc(1'b1, 1'b1, 1'b0, 65535, -2048, 1'b1);
      checks++; if (dco_code !== 16'd64991 || dco_code !== DCO_W'(m_code)) begin
         errors++; $display("FAIL sat_windup got=%0d exp=64991", dco_code);
      end
   endtask

   task automatic test_skip();
      int tgt;
      tgt = int'($urandom_range(1000, 60000));
      cyc(1'b1, 1'b0, 1'b1, tgt, 500, 1'b0);
      repeat (1 + ACQ) cyc(1'b1, 1'b1, 1'b1, tgt, 500, 1'b0);
      checks++; if (state !== 2'd2 || dco_code !== DCO_W'(tgt)) begin
         errors++; $display("FAIL skip_entry got state=%0d code=%0d exp 2/%0d", state, dco_code, tgt);
      end
      for (int k = 0; k < LCM; k++) begin
         cyc(1'b1, 1'b1, 1'b1, tgt, 500, 1'b0);
         checks++; if (dco_code !== DCO_W'(tgt) || lock !== (k == LCM - 1)) begin
            errors++; $display("FAIL skip_lock k=%0d got code=%0d lock=%0b exp code=%0d", k, dco_code, lock, tgt);
         end
      end
   endtask

   task automatic test_random();
      int  tgt, p;
      bit  r, e, s, v, noisy;
      tgt   = int'($urandom_range(0, 65535));
      noisy = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, tgt, 0, 1'b0);
      for (int i = 0; i < 1500; i++) begin
         if (i % 32 == 0) noisy = bit'($urandom_range(0, 1));
         r = ($urandom_range(0, 499) != 0);
         e = ($urandom_range(0, 299) != 0);
         s = ($urandom_range(0, 59) == 0);
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) tgt = int'($urandom_range(0, 65535));
         if (noisy) p = int'($urandom_range(0, 4095)) - 2048;
         else       p = int'($urandom_range(0, 16)) - 8;
         cyc(r, e, s, tgt, p, v);
         checks++;
         if (dco_code !== DCO_W'(m_code) || state !== 2'(m_state) || lock !== m_lock ||
             freq_acq_done !== m_done || lost_lock !== m_lost) begin
            errors++;
            $display("FAIL rand_cycle i=%0d got code=%0d st=%0d lk=%0b dn=%0b ll=%0b exp code=%0d st=%0d lk=%0b dn=%0b ll=%0b",
                     i, dco_code, state, lock, freq_acq_done, lost_lock, m_code, m_state, m_lock, m_done, m_lost);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; skip_phase_lock = 1'b0;
      target_code = '0; pe = '0; pe_valid = 1'b0;
      test_reset();
      test_ramp();
      test_integral();
      test_lock();
      test_abort();
      test_saturation();
      test_skip();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_dlf_lock_ctrl.md
Name: pll_dlf_lock_ctrl

Overview:
Parametrised digital successor to the behavioural PLL core's frequency-acquisition and lock logic. It runs on the reference clock and combines four functions:
- a timed linear frequency ramp from an initial DCO code to a target code;
- a proportional-integral (PI) digital loop filter driven by signed phase-error samples from the time-to-digital converter (TDC);
- lock detection with a programmable tolerance and count;
- unlock hysteresis, plus a skip-phase-lock mode.

It sits between the TDC and the DCO control word inside the PLL.

Parameters:
PE_W, 12, width of signed phase-error input
DCO_W, 16, width of unsigned DCO control word
KP_SHIFT, 2, proportional gain = 2^-KP_SHIFT (arithmetic right shift)
KI_SHIFT, 6, integral gain = 2^-KI_SHIFT (arithmetic right shift)
ACQ_CYCLES, 64, length of frequency ramp in rclk cycles (>=1)
INIT_CODE, 16384, DCO code in IDLE and at ramp start
LOCK_TOL, 8, max |pe| counted as a good sample
LOCK_COUNT_MAX, 10, consecutive good samples required to declare lock
UNLOCK_COUNT_MAX, 4, consecutive bad samples required to drop lock

Ports:
rclk  input  1  reference clock; all logic is on its posedge
rst_n  input  1  synchronous active-low reset
en  input  1  PLL enable
skip_phase_lock  input  1  1 = hold the target code and ignore pe
target_code  input  DCO_W  DCO code for the nominal fbdiv frequency
pe  input  PE_W  signed phase error; positive means vclk late, so the code is raised
pe_valid  input  1  pe sample strobe, one sample per cycle
dco_code  output  DCO_W  DCO control word
state  output  2  IDLE=0, ACQ=1, TRACK=2, LOCKED=3
freq_acq_done  output  1  ramp complete
lock  output  1  lock indicator
lost_lock  output  1  one-cycle pulse on LOCKED->TRACK

Behaviour:
- Interface (already decided): one clock, rclk; reset is synchronous and active-low (rst_n). rst_n=0 at a posedge sets:
  - state=IDLE, dco_code=INIT_CODE;
  - integ=0, acq_cnt=0, good_cnt=0, bad_cnt=0;
  - freq_acq_done=0, lock=0, lost_lock=0.
- Priority: rst_n dominates en; en=0 dominates all other conditions.
- en=0 in any state: next edge goes to IDLE with dco_code=INIT_CODE, all counters cleared, lock=0, freq_acq_done=0. lost_lock is not pulsed.
- IDLE: dco_code held at INIT_CODE; en=1 moves to ACQ with acq_cnt=0.
- ACQ, each cycle:
  - dco_code <= INIT_CODE + ((target_code - INIT_CODE)*(acq_cnt+1))/ACQ_CYCLES;
  - the product and quotient are signed, at least DCO_W+clog2(ACQ_CYCLES)+2 bits wide, and division truncates toward zero;
  - target_code is sampled live every cycle;
  - acq_cnt++.
- ACQ exit: on the cycle acq_cnt==ACQ_CYCLES-1, dco_code <= target_code, integ <= target_code, freq_acq_done <= 1, state <= TRACK. pe is ignored throughout ACQ.
- Integrator: signed, DCO_W+2 bits wide.
- TRACK/LOCKED filter, on pe_valid=1 and skip_phase_lock=0:
  - i_n = sat(integ + (pe>>>KI_SHIFT));
  - integ <= i_n;
  - dco_code <= clamp(i_n + (pe>>>KP_SHIFT), 0, 2^DCO_W-1);
  - sat clamps the integrator to the same range as dco_code (anti-windup).
  - With pe_valid=0, integ and dco_code hold.
- skip_phase_lock=1 in TRACK/LOCKED: dco_code <= target_code and integ <= target_code every cycle. Every cycle counts as a good sample, regardless of pe_valid.
- Good/bad samples:
  - |pe| is computed with the most negative pe saturated to 2^(PE_W-1)-1.
  - good = |pe| <= LOCK_TOL; bad = |pe| > LOCK_TOL.
  - Samples count only when pe_valid=1 (except in skip mode, as above).
- TRACK:
  - good sample: good_cnt++;
  - bad sample: good_cnt=0;
  - the edge on which good_cnt reaches LOCK_COUNT_MAX sets state=LOCKED and lock=1 (the 10th good sample's edge), and clears bad_cnt.
- LOCKED:
  - bad sample: bad_cnt++;
  - good sample: bad_cnt=0;
  - the edge on which bad_cnt reaches UNLOCK_COUNT_MAX sets state=TRACK, lock=0, lost_lock=1 for that cycle only, and good_cnt=0.
- Invariants:
  - lock==(state==LOCKED);
  - freq_acq_done==(state is TRACK or LOCKED);
  - lost_lock is 0 whenever it is not the exit cycle above.
- Non-overlap: counters never wrap; good_cnt stays <= LOCK_COUNT_MAX and bad_cnt stays <= UNLOCK_COUNT_MAX.
- Mid-ramp: target_code changing during ACQ bends the ramp toward the new value; the final code equals target_code at exit.

Test Plan:
- Ramp: rst_n released, en=1, target_code=20000 -> 1st ACQ cycle dco_code=16440; after 64 cycles dco_code=20000 and freq_acq_done=1, state=2.
- Integral step: TRACK, pe=+64 with pe_valid every cycle -> 1st sample dco_code=20017, then +1 per sample (20018, 20019, ...).
- Lock acquire and loss:
  - pe=0 valid every cycle -> lock rises on the 10th sample edge, state=3;
  - then pe=100 x4 -> lock falls on the 4th, lost_lock is high for exactly 1 cycle, state=2;
  - a pe=100,100,0,100,100 pattern must not unlock.
- Saturation: target_code=65535, pe=+2047 continuously -> dco_code stays 65535; after pe=-2048, dco_code drops within 1 sample (no windup).
- Skip mode: skip_phase_lock=1, pe=500, pe_valid=0 -> dco_code=target_code; lock at TRACK-entry+10 cycles.
- Abort: en=0 mid-ACQ or in LOCKED -> next edge state=0, dco_code=16384, lock=0, no lost_lock pulse; rst_n=0 with en=1 -> same reset values.
